// File: rtl/md_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: md_op codes, FSM states and
// a helper that classifies which ops start a multi-cycle operation.
package md_sequencer_pkg;

    typedef enum logic [2:0] {
        MdMult  = 3'd0,
        MdMultu = 3'd1,
        MdDiv   = 3'd2,
        MdDivu  = 3'd3,
        MdMthi  = 3'd4,
        MdMtlo  = 3'd5
    } md_op_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide core: signed/unsigned 32x32 products and
// truncating quotient/remainder, with divide-by-zero flagged via div0.
module md_arith
    import md_sequencer_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor_s;
    logic [31:0] divisor_u;
    logic [31:0] q_s_mag;
    logic [31:0] r_s_mag;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        b_zero;

    // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Magnitude division keeps 0x80000000 / -1 well defined: the quotient wraps to 0x80000000.
    assign mag_a     = a[31] ? (~a + 32'd1) : a;
    assign mag_b     = b[31] ? (~b + 32'd1) : b;
    assign b_zero    = (b == 32'd0);
    assign divisor_s = b_zero ? 32'd1 : mag_b;
    assign divisor_u = b_zero ? 32'd1 : b;
    assign q_s_mag   = mag_a / divisor_s;
    assign r_s_mag   = mag_a % divisor_s;
    assign q_u       = a / divisor_u;
    assign r_u       = a % divisor_u;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        div0   = 1'b0;
        case (md_op)
            MdMult: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MdMultu: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MdDiv: begin
                div0   = b_zero;
                res_lo = (a[31] ^ b[31]) ? (~q_s_mag + 32'd1) : q_s_mag;
                res_hi = a[31] ? (~r_s_mag + 32'd1) : r_s_mag;
            end
            MdDivu: begin
                div0   = b_zero;
                res_lo = q_u;
                res_hi = r_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div controller beside the E-stage ALU: owns HI/LO, models
// latency with a countdown and raises stall for md instructions waiting in D.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_state_e       state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     pend_hi_q, pend_hi_d;
    logic [31:0]     pend_lo_q, pend_lo_d;
    logic            pend_wr_q, pend_wr_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    logic [31:0]     res_hi;
    logic [31:0]     res_lo;
    logic            div0;

    md_arith u_arith (
        .md_op  (md_op),
        .a      (a),
        .b      (b),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (md_op)
                        MdMult, MdMultu, MdDiv, MdDivu: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            // A divide by zero still burns its latency but commits nothing.
                            pend_wr_d = ~div0;
                            count_d   = is_muldiv(md_op) && (md_op == MdMult || md_op == MdMultu)
                                        ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                            state_d   = StRun;
                        end
                        MdMthi:  hi_d = a;
                        MdMtlo:  lo_d = a;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (count_q == CntW'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    count_d = '0;
                    state_d = StIdle;
                end else begin
                    count_d = count_q - CntW'(1);
                end
            end
        endcase
    end

    assign busy  = (state_q == StRun);
    assign stall = d_is_md && (busy || (start && is_muldiv(md_op)));
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
